rc5_key_expand: RTL and testbench
=================================

# rc5_key_expand

- Iterative RC5-32/12/16 key-schedule generator.
- Takes the 128-bit user key and runs the standard init and mix passes, one round-key word per cycle.
- Presents the 26-word expanded table S[0..25] as one 832-bit bus for the `encrypt` and `decrypt` cores.
- Replaces the constant-output `keyGen`; consumers sample the table only while `key_vld` is high.

## Interface
Parameters:
- `P_CONST`, 32'hB7E15163, RC5 magic P.
- `Q_CONST`, 32'h9E3779B9, RC5 magic Q.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `clr`  in  1  reset; one clock; reset is asynchronous and active-high.
- `start`  in  1  request expansion of `din_key`; sampled only in IDLE or DONE.
- `din_key`  in  128  user key; byte K[k] = `din_key[127-8k -: 8]`, k=0..15.
- `busy`  out  1  high in LOAD/INIT/MIX.
- `key_vld`  out  1  high only in DONE; table stable and complete.
- `skey`  out  832  S[i] at `skey[32*i+31 -: 32]`, i=0..25; same packing as `keyOut`.

## Operation
- States: IDLE, INIT, MIX, DONE.
- IDLE or DONE with `start`=1:
  - Load L[j] = {K[4j+3],K[4j+2],K[4j+1],K[4j]}, j=0..3.
  - Clear A and B to 0 and zero the index counters.
  - Go to INIT.
  - The key is captured only at this edge; later `din_key` changes are ignored.
- INIT:
  - Each cycle writes S[ii] = P_CONST + ii*Q_CONST.
  - Use a running-sum register, not a multiplier.
  - ii runs 0..25; after ii=25, ii returns to 0 and the state goes to MIX.
- MIX runs 78 cycles (3*max(26,4)). Each cycle:
  - A' = (S[i] + A + B) <<< 3; S[i] = A'.
  - B' = (L[j] + A' + B) <<< (A'+B)[4:0]; L[j] = B'.
  - i = (i+1) mod 26 (wraps 25→0); j = (j+1) mod 4 (wraps 3→0).
  - A' is combinational within the cycle and feeds B' in the same cycle.
- A 7-bit mix counter ends MIX at count 77 and moves to DONE.
- DONE holds S until the next `start` or `clr`.
- Arithmetic is mod 2^32 with all sums truncated to 32 bits.
- A rotate amount of 0 is an identity; no shift by 32 is allowed.
- `start` in INIT or MIX is ignored; there is no abort except `clr`.
- `clr` asserted mid-operation:
  - Immediately forces IDLE and zeroes S, L, A, B and the counters.
  - Drives `busy`=0 and `key_vld`=0.
- Reset values: `busy`=0, `key_vld`=0, `skey`=832'h0.
- `skey` reflects the live S array, so partial values are visible while busy. Consumers must gate on `key_vld`.

## Timing
- Edge E0 samples `start`=1. From E1 on, `busy`=1 and `key_vld`=0.
- INIT writes occur at E1..E26; MIX iterations occur at E27..E104.
- After E104: `key_vld`=1 and `busy`=0, so latency is 104 cycles.
- `start` at a DONE edge: `key_vld` falls and `busy` rises after that same edge.
- Back-to-back requests cost 104 cycles each with no idle gap required.
- `start` and `clr` together: `clr` wins.

## Configuration
- `RC5_KEYGEN_FASTINIT_EN` defined:
  - The LOAD edge also writes all 26 S[i] = P+i*Q in parallel from constants.
  - The INIT state is skipped; MIX runs at E1..E78.
  - `key_vld` is high after E78 (latency 78).
- Not defined: the 26-cycle serial INIT described above (latency 104).
- The final S table is identical in both builds.

## Test plan
- Reset mid-MIX:
  - Pulse `clr` at E50 → same cycle, asynchronously: `busy`=0, `key_vld`=0, `skey`=0.
  - Next `start` restarts from IDLE and completes in full latency.
- INIT snapshot, serial build, zero key, `start` at E0 → after E26:
  - `skey[31:0]`=32'hB7E15163, `skey[63:32]`=32'h5618CB1C, `skey[831:800]`=32'h2B4C3474.
  - `key_vld`=0.
- First mix step, zero key → after the first MIX edge, S[0]=32'hBF0A8B1D.
- End-to-end, zero key:
  - After `key_vld`, drive `encrypt` with `dinValue`=64'h0.
  - Required: A=32'hEEDBA521, B=32'h6D8F4B15 (RC5 paper vector 21A5DBEE 154B8F6D).
  - `decrypt` of that result returns 64'h0.
- Restart and ignore rules:
  - `start` pulsed at E40 is ignored; `key_vld` still rises after E104.
  - A new key started in DONE gives `key_vld` 0 for exactly 104 cycles.
  - The full 832-bit table matches the bench golden model.
- FASTINIT build, random keys ×100 → `key_vld` after E78; `skey` bit-identical to the serial build.

Source files
------------

// File: rtl/rc5_key_expand.sv
// Iterative RC5-32/12/16 key-schedule generator: 128-bit key in, 26-word table S[0..25] out.
// Build option RC5_KEYGEN_FASTINIT_EN loads the P+i*Q table in parallel and skips the serial INIT pass.
module rc5_key_expand #(
    parameter logic [31:0] P_CONST = 32'hB7E15163,
    parameter logic [31:0] Q_CONST = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [127:0] din_key,
    output logic         busy,
    output logic         key_vld,
    output logic [831:0] skey
);
    typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

    state_t      state_reg;
    logic [31:0] s_reg [26];
    logic [31:0] l_reg [4];
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] sum_reg;
    logic [4:0]  i_reg;
    logic [1:0]  j_reg;
    logic [6:0]  mix_cnt_reg;
    logic        busy_reg;
    logic        key_vld_reg;

    logic [31:0] key_word [4];
    logic [31:0] a_next;
    logic [31:0] b_next;
    logic [31:0] ab_sum;

    // Rotate via a doubled word so a zero amount never becomes a 32-bit shift.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    // Little-endian word assembly: L[j] = {K[4j+3], K[4j+2], K[4j+1], K[4j]}.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_word
            assign key_word[gi] = {din_key[127-8*(4*gi+3) -: 8], din_key[127-8*(4*gi+2) -: 8],
                                   din_key[127-8*(4*gi+1) -: 8], din_key[127-8*(4*gi) -: 8]};
        end
        for (genvar gi = 0; gi < 26; gi++) begin : g_skey
            assign skey[32*gi +: 32] = s_reg[gi];
        end
    endgenerate

    always_comb begin
        a_next = rotl(s_reg[i_reg] + a_reg + b_reg, 5'd3);
        ab_sum = a_next + b_reg;
        b_next = rotl(l_reg[j_reg] + ab_sum, ab_sum[4:0]);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= IDLE;
            for (int k = 0; k < 26; k++) s_reg[k] <= '0;
            for (int k = 0; k < 4; k++)  l_reg[k] <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            i_reg       <= '0;
            j_reg       <= '0;
            mix_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            key_vld_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        for (int k = 0; k < 4; k++) l_reg[k] <= key_word[k];
                        a_reg       <= '0;
                        b_reg       <= '0;
                        sum_reg     <= P_CONST;
                        i_reg       <= '0;
                        j_reg       <= '0;
                        mix_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        key_vld_reg <= 1'b0;
`ifdef RC5_KEYGEN_FASTINIT_EN
                        for (int k = 0; k < 26; k++) s_reg[k] <= P_CONST + Q_CONST * 32'(k);
                        state_reg   <= MIX;
`else
                        state_reg   <= INIT;
`endif
                    end
                end
                INIT: begin
                    s_reg[i_reg] <= sum_reg;
                    sum_reg      <= sum_reg + Q_CONST;
                    if (i_reg == 5'd25) begin
                        i_reg     <= '0;
                        state_reg <= MIX;
                    end else begin
                        i_reg <= i_reg + 5'd1;
                    end
                end
                MIX: begin
                    s_reg[i_reg] <= a_next;
                    l_reg[j_reg] <= b_next;
                    a_reg        <= a_next;
                    b_reg        <= b_next;
                    i_reg        <= (i_reg == 5'd25) ? 5'd0 : i_reg + 5'd1;
                    j_reg        <= j_reg + 2'd1;
                    mix_cnt_reg  <= mix_cnt_reg + 7'd1;
                    if (mix_cnt_reg == 7'd77) begin
                        state_reg   <= DONE;
                        busy_reg    <= 1'b0;
                        key_vld_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign key_vld = key_vld_reg;
endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed + random bench for rc5_key_expand against a plain-arithmetic RC5 key-schedule model.
// Honours RC5_KEYGEN_FASTINIT_EN for the expected latency.
module tb_rc5_key_expand;
    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [127:0] din_key;
    logic         busy;
    logic         key_vld;
    logic [831:0] skey;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt;

`ifdef RC5_KEYGEN_FASTINIT_EN
    localparam int LAT = 78;
`else
    localparam int LAT = 104;
`endif

    rc5_key_expand dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .din_key (din_key),
        .busy    (busy),
        .key_vld (key_vld),
        .skey    (skey)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [831:0] obs, input logic [831:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << (n % 32)) | (x >> ((32 - (n % 32)) % 32));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> (n % 32)) | (x << ((32 - (n % 32)) % 32));
    endfunction

    // Textbook RC5 key schedule, c = 4 words, t = 26, 3*t mixing steps.
    function automatic logic [831:0] model(input logic [127:0] key);
        logic [31:0]  s [26];
        logic [31:0]  l [4];
        logic [31:0]  a = 0, b = 0;
        int           i = 0, j = 0;
        logic [831:0] tab;
        for (int w = 0; w < 4; w++) l[w] = 0;
        for (int k = 0; k < 16; k++)
            l[k/4] = l[k/4] | (32'(key[127-8*k -: 8]) << (8 * (k % 4)));
        for (int k = 0; k < 26; k++) s[k] = 32'hB7E15163 + 32'(k) * 32'h9E3779B9;
        for (int n = 0; n < 78; n++) begin
            a = rl(s[i] + a + b, 3);
            s[i] = a;
            b = rl(l[j] + a + b, int'((a + b) % 32));
            l[j] = b;
            i = (i + 1) % 26;
            j = (j + 1) % 4;
        end
        for (int k = 0; k < 26; k++) tab[32*k +: 32] = s[k];
        return tab;
    endfunction

    function automatic logic [31:0] sw(input logic [831:0] t, input int k);
        return t[32*k +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives start for exactly one edge (E0); leaves the bench at the negedge after E0.
    task automatic start_key(input logic [127:0] k);
        @(negedge clk);
        start   = 1'b1;
        din_key = k;
        step();
        start    = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic wait_done(input string tag);
        while (!key_vld && edge_cnt < 300) begin
            step();
            edge_cnt++;
        end
        chk({tag, "_latency"}, edge_cnt, LAT);
        chk({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin : main
        logic [127:0] k1, k2;
        logic [31:0]  a, b;
        logic [831:0] tab;

        clr = 1'b1; start = 1'b0; din_key = '0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_vld", key_vld, 1'b0);
        chk("rst_skey", skey, 832'h0);
        clr = 1'b0;

        // Zero key: intermediate snapshots, final table, RC5 paper vector.
        start_key('0);
        chk("e0_busy", busy, 1'b1);
        chk("e0_vld", key_vld, 1'b0);
`ifndef RC5_KEYGEN_FASTINIT_EN
        repeat (26) begin step(); edge_cnt++; end
        chk("init_s0", sw(skey, 0), 32'hB7E15163);
        chk("init_s1", sw(skey, 1), 32'h5618CB1C);
        chk("init_s25", sw(skey, 25), 32'h2B4C3474);
        chk("init_vld", key_vld, 1'b0);
`endif
        step(); edge_cnt++;
        chk("mix1_s0", sw(skey, 0), 32'hBF0A8B1D);
        wait_done("zero");
        chk("zero_table", skey, model('0));
        tab = skey;
        a = sw(tab, 0);
        b = sw(tab, 1);
        for (int r = 1; r <= 12; r++) begin
            a = rl(a ^ b, int'(b % 32)) + sw(tab, 2*r);
            b = rl(b ^ a, int'(a % 32)) + sw(tab, 2*r+1);
        end
        chk("enc_a", a, 32'hEEDBA521);
        chk("enc_b", b, 32'h6D8F4B15);
        for (int r = 12; r >= 1; r--) begin
            b = rr(b - sw(tab, 2*r+1), int'(a % 32)) ^ a;
            a = rr(a - sw(tab, 2*r), int'(b % 32)) ^ b;
        end
        b = b - sw(tab, 1);
        a = a - sw(tab, 0);
        chk("dec_zero", {b, a}, 64'h0);

        // New key from DONE, with a second start at E40 that must be ignored.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k1;
        start_key(k1);
        chk("redo_vld_fall", key_vld, 1'b0);
        chk("redo_busy", busy, 1'b1);
        while (edge_cnt < 39) begin step(); edge_cnt++; end
        start = 1'b1; din_key = k2;
        step(); edge_cnt++;
        start = 1'b0;
        wait_done("ignore");
        chk("ignore_table", skey, model(k1));

        // Asynchronous clear mid-MIX, then a full restart.
        start_key(k2);
        while (edge_cnt < 49) begin step(); edge_cnt++; end
        @(posedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_busy", busy, 1'b0);
        chk("clr_vld", key_vld, 1'b0);
        chk("clr_skey", skey, 832'h0);
        @(negedge clk);
        clr = 1'b0;
        start_key(k2);
        wait_done("after_clr");
        chk("after_clr_table", skey, model(k2));

        // Back-to-back random keys.
        for (int n = 0; n < 100; n++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            start_key(k1);
            wait_done("rand");
            chk("rand_table", skey, model(k1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
